// File: rtl/symbolic_qkd_bank_if.sv
// Port bundle between the key-provisioning controller (master) and the QKD cell bank (slave).
interface symbolic_qkd_bank_if #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4,
  parameter int ID_W   = 4,
  parameter int TIME_W = 8
);
  localparam int ADDR_W = $clog2(DEPTH);
  localparam int CNT_W  = $clog2(DEPTH + 1);

  logic              init;
  logic [ADDR_W-1:0] init_addr;
  logic [ID_W-1:0]   init_id;
  logic [TIME_W-1:0] init_t_start;
  logic [TIME_W-1:0] init_t_end;
  logic              read;
  logic [ADDR_W-1:0] rd_addr;
  logic [1:0]        basis_in;
  logic [1:0]        phase_in;
  logic [ID_W-1:0]   identity_in;
  logic [TIME_W-1:0] time_in;
  logic              fuse_blow;
  logic [DATA_W-1:0] value_out;
  logic              rd_valid;
  logic              rd_ok;
  logic              pad_enable;
  logic              fuse_fire;
  logic [CNT_W-1:0]  live_count;
  logic              locked;

  modport master (
    output init, init_addr, init_id, init_t_start, init_t_end,
    output read, rd_addr, basis_in, phase_in, identity_in, time_in, fuse_blow,
    input  value_out, rd_valid, rd_ok, pad_enable, fuse_fire, live_count, locked
  );

  modport slave (
    input  init, init_addr, init_id, init_t_start, init_t_end,
    input  read, rd_addr, basis_in, phase_in, identity_in, time_in, fuse_blow,
    output value_out, rd_valid, rd_ok, pad_enable, fuse_fire, live_count, locked
  );
endinterface

// File: rtl/symbolic_qkd_bank.sv
// Bank of read-once QKD cells with LFSR-derived tags, registered one-cycle reads and global lockout.
// Define QKD_FAIL_LOCKOUT_EN to let MAX_FAILS failed reads lock the bank like fuse_blow.
module symbolic_qkd_bank #(
  parameter int          DATA_W    = 8,
  parameter int          DEPTH     = 4,
  parameter int          ID_W      = 4,
  parameter int          TIME_W    = 8,
  parameter int          MAX_FAILS = 3,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input logic               clk,
  input logic               reset_n,
  symbolic_qkd_bank_if.slave bus
);
  localparam int ADDR_W = $clog2(DEPTH);
  localparam int CNT_W  = $clog2(DEPTH + 1);

  typedef enum logic [1:0] {EMPTY, ARMED, COLLAPSED, DEAD} cell_state_t;

  logic [15:0]       lfsr_reg;
  logic [15:0]       lfsr_next;
  logic [DATA_W-1:0] noise;
  logic              locked_reg;
  logic              lock_now;
  logic [DEPTH-1:0]  rd_sel;
  logic [DEPTH-1:0]  init_sel;
  logic [DEPTH-1:0]  armed_vec;
  logic [DEPTH-1:0]  auth_vec;
  logic [DATA_W-1:0] cell_value [DEPTH];
  logic [DATA_W-1:0] sel_value;
  logic              rd_auth;
  logic              rd_armed;
  logic              ok_next;
  logic              live_inc;
  logic              live_dec;
  logic [DATA_W-1:0] value_out_reg;
  logic              rd_valid_reg;
  logic              rd_ok_reg;
  logic              fuse_fire_reg;
  logic [CNT_W-1:0]  live_count_reg;

  // Fibonacci form of x^16+x^14+x^13+x^11+1, shifting toward bit 0
  assign lfsr_next = {lfsr_reg[0] ^ lfsr_reg[2] ^ lfsr_reg[3] ^ lfsr_reg[5], lfsr_reg[15:1]};
  assign noise     = lfsr_reg[DATA_W-1:0];

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_cell
    cell_state_t       state_reg;
    logic [DATA_W-1:0] value_reg;
    logic [1:0]        basis_reg;
    logic [1:0]        phase_reg;
    logic [ID_W-1:0]   id_reg;
    logic [TIME_W-1:0] t_start_reg;
    logic [TIME_W-1:0] t_end_reg;

    assign rd_sel[gi]     = bus.read && (bus.rd_addr == ADDR_W'(gi));
    assign init_sel[gi]   = bus.init && (bus.init_addr == ADDR_W'(gi));
    assign armed_vec[gi]  = (state_reg == ARMED);
    assign cell_value[gi] = value_reg;
    assign auth_vec[gi]   = armed_vec[gi] && !locked_reg
                            && (bus.basis_in == basis_reg) && (bus.phase_in == phase_reg)
                            && (bus.identity_in == id_reg)
                            && (bus.time_in >= t_start_reg) && (bus.time_in <= t_end_reg);

    // Lock beats read beats init; a read to this cell masks a same-cycle init
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        state_reg   <= EMPTY;
        value_reg   <= '0;
        basis_reg   <= '0;
        phase_reg   <= '0;
        id_reg      <= '0;
        t_start_reg <= '0;
        t_end_reg   <= '0;
      end else if (lock_now || locked_reg) begin
        state_reg   <= DEAD;
        value_reg   <= '0;
        basis_reg   <= '0;
        phase_reg   <= '0;
        id_reg      <= '0;
        t_start_reg <= '0;
        t_end_reg   <= '0;
      end else if (rd_sel[gi]) begin
        if (state_reg == ARMED) begin
          state_reg <= COLLAPSED;
          value_reg <= noise;
        end
      end else if (init_sel[gi]) begin
        state_reg   <= ARMED;
        value_reg   <= noise;
        basis_reg   <= lfsr_reg[1:0];
        phase_reg   <= lfsr_reg[3:2];
        id_reg      <= bus.init_id;
        t_start_reg <= bus.init_t_start;
        t_end_reg   <= bus.init_t_end;
      end
    end
  end

  always_comb begin
    sel_value = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (rd_sel[i]) sel_value = sel_value | cell_value[i];
    end
  end

  // Out-of-range addresses select no cell and therefore fall through as failed reads
  assign rd_auth  = |(rd_sel & auth_vec);
  assign rd_armed = |(rd_sel & armed_vec);
  assign ok_next  = bus.read && rd_auth && !bus.fuse_blow;
  assign live_dec = bus.read && rd_armed;
  assign live_inc = |(init_sel & ~rd_sel & ~armed_vec);

`ifdef QKD_FAIL_LOCKOUT_EN
  localparam int FAIL_W = $clog2(MAX_FAILS + 1);
  logic [FAIL_W-1:0] fail_count_reg;
  logic [FAIL_W-1:0] fail_count_next;
  logic              fail_event;

  assign fail_event = bus.read && !locked_reg && !bus.fuse_blow && !rd_auth;

  always_comb begin
    fail_count_next = fail_count_reg;
    if (fail_event && (fail_count_reg != FAIL_W'(MAX_FAILS))) begin
      fail_count_next = fail_count_reg + 1'b1;
    end
  end

  assign lock_now = bus.fuse_blow || (fail_event && (fail_count_next == FAIL_W'(MAX_FAILS)));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) fail_count_reg <= '0;
    else          fail_count_reg <= fail_count_next;
  end
`else
  assign lock_now = bus.fuse_blow;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      lfsr_reg       <= LFSR_SEED;
      locked_reg     <= 1'b0;
      value_out_reg  <= '0;
      rd_valid_reg   <= 1'b0;
      rd_ok_reg      <= 1'b0;
      fuse_fire_reg  <= 1'b0;
      live_count_reg <= '0;
    end else begin
      lfsr_reg      <= lfsr_next;
      locked_reg    <= locked_reg | lock_now;
      rd_valid_reg  <= bus.read;
      rd_ok_reg     <= ok_next;
      value_out_reg <= ok_next ? sel_value : noise;
      fuse_fire_reg <= bus.read && rd_armed && !locked_reg && !bus.fuse_blow;
      if (lock_now || locked_reg) begin
        live_count_reg <= '0;
      end else begin
        live_count_reg <= live_count_reg + CNT_W'(live_inc) - CNT_W'(live_dec);
      end
    end
  end

  assign bus.value_out  = value_out_reg;
  assign bus.rd_valid   = rd_valid_reg;
  assign bus.rd_ok      = rd_ok_reg;
  assign bus.pad_enable = rd_valid_reg & rd_ok_reg & ~locked_reg;
  assign bus.fuse_fire  = fuse_fire_reg;
  assign bus.live_count = live_count_reg;
  assign bus.locked     = locked_reg;
endmodule

// File: tb/tb_symbolic_qkd_bank.sv
// Scoreboard bench for symbolic_qkd_bank: reads push expected responses, a negedge monitor pops them.
module tb_symbolic_qkd_bank;
  localparam int DATA_W = 8;
  localparam int DEPTH  = 4;
  localparam int ID_W   = 4;
  localparam int TIME_W = 8;

  typedef struct packed {
    logic              ok;
    logic [DATA_W-1:0] val;
    logic              fuse;
  } exp_t;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   total = 0;
  int   bad = 0;
  exp_t exp_q [$];

  logic [15:0]       mlfsr;
  logic [DATA_W-1:0] m_val   [DEPTH];
  logic [1:0]        m_basis [DEPTH];
  logic [1:0]        m_phase [DEPTH];

  symbolic_qkd_bank_if #(.DATA_W(DATA_W), .DEPTH(DEPTH), .ID_W(ID_W), .TIME_W(TIME_W)) bus ();

  symbolic_qkd_bank #(
    .DATA_W(DATA_W), .DEPTH(DEPTH), .ID_W(ID_W), .TIME_W(TIME_W),
    .MAX_FAILS(3), .LFSR_SEED(16'hACE1)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .bus(bus)
  );

  always #5 clk = ~clk;

  // Reference LFSR written from the polynomial taps 16,14,13,11
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) mlfsr <= 16'hACE1;
    else          mlfsr <= (mlfsr >> 1) | (((mlfsr ^ (mlfsr >> 2) ^ (mlfsr >> 3) ^ (mlfsr >> 5)) & 16'h0001) << 15);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (reset_n && bus.rd_valid) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL resp_unexpected: got rd_valid=1 expected no response");
        end else begin
          e = exp_q.pop_front();
          check("resp_rd_ok", bus.rd_ok, e.ok);
          check("resp_value", bus.value_out, e.val);
          check("resp_pad_enable", bus.pad_enable, e.ok);
          check("resp_fuse_fire", bus.fuse_fire, e.fuse);
          $display("read response: ok=%0d value=%0h fuse=%0d", bus.rd_ok, bus.value_out, bus.fuse_fire);
        end
      end
    end
  end

  task automatic clear_inputs();
    bus.init = 1'b0; bus.init_addr = '0; bus.init_id = '0;
    bus.init_t_start = '0; bus.init_t_end = '0;
    bus.read = 1'b0; bus.rd_addr = '0; bus.basis_in = '0; bus.phase_in = '0;
    bus.identity_in = '0; bus.time_in = '0; bus.fuse_blow = 1'b0;
  endtask

  task automatic step();
    @(negedge clk);
    clear_inputs();
  endtask

  task automatic set_init(input int addr, input logic [ID_W-1:0] id,
                          input logic [TIME_W-1:0] ts, input logic [TIME_W-1:0] te);
    m_val[addr]   = mlfsr[DATA_W-1:0];
    m_basis[addr] = mlfsr[1:0];
    m_phase[addr] = mlfsr[3:2];
    bus.init = 1'b1; bus.init_addr = 2'(addr); bus.init_id = id;
    bus.init_t_start = ts; bus.init_t_end = te;
    $display("init cell %0d id=%0h window=%0d..%0d", addr, id, ts, te);
  endtask

  task automatic set_read(input int addr, input logic [1:0] b, input logic [1:0] p,
                          input logic [ID_W-1:0] id, input logic [TIME_W-1:0] t,
                          input logic ok, input logic fuse);
    exp_t e;
    e.ok   = ok;
    e.val  = ok ? m_val[addr] : mlfsr[DATA_W-1:0];
    e.fuse = fuse;
    exp_q.push_back(e);
    bus.read = 1'b1; bus.rd_addr = 2'(addr); bus.basis_in = b; bus.phase_in = p;
    bus.identity_in = id; bus.time_in = t;
    $display("read cell %0d id=%0h time=%0d expect ok=%0d fuse=%0d", addr, id, t, ok, fuse);
  endtask

  task automatic set_read_auth(input int addr, input logic [ID_W-1:0] id,
                               input logic [TIME_W-1:0] t, input logic ok, input logic fuse);
    set_read(addr, m_basis[addr], m_phase[addr], id, t, ok, fuse);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_value_out"}, bus.value_out, 0);
    check({tag, "_rd_valid"}, bus.rd_valid, 0);
    check({tag, "_rd_ok"}, bus.rd_ok, 0);
    check({tag, "_pad_enable"}, bus.pad_enable, 0);
    check({tag, "_fuse_fire"}, bus.fuse_fire, 0);
    check({tag, "_live_count"}, bus.live_count, 0);
    check({tag, "_locked"}, bus.locked, 0);
  endtask

  initial begin : stimulus
    clear_inputs();
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    reset_n = 1'b1;

    // Authorized read of cell 2, then a second read of the consumed cell
    set_init(2, 4'hA, 8'd10, 8'd200); step();
    check("live_after_init2", bus.live_count, 1);
    set_read_auth(2, 4'hA, 8'd50, 1'b1, 1'b1); step();
    check("live_after_read2", bus.live_count, 0);
    set_read_auth(2, 4'hA, 8'd50, 1'b0, 1'b0); step();

    // Time just past the window end still collapses the cell
    set_init(1, 4'h5, 8'd10, 8'd200); step();
    check("live_after_init1", bus.live_count, 1);
    set_read_auth(1, 4'h5, 8'd201, 1'b0, 1'b1); step();
    check("live_after_late_read1", bus.live_count, 0);

    // Same-cycle init and read of cell 3: read wins, init dropped
    set_init(3, 4'h7, 8'd0, 8'd255); step();
    check("live_after_init3", bus.live_count, 1);
    set_read_auth(3, 4'h7, 8'd100, 1'b1, 1'b1);
    set_init(3, 4'h7, 8'd0, 8'd255); step();
    check("live_after_init_read3", bus.live_count, 0);
    step();
    check("init3_ignored", bus.live_count, 0);

    // Reset dropped while an authorized response is on the outputs
    set_init(2, 4'h3, 8'd0, 8'd255); step();
    set_read_auth(2, 4'h3, 8'd100, 1'b1, 1'b1); step();
    #1 reset_n = 1'b0;
    #1;
    check("abort_rd_valid", bus.rd_valid, 0);
    check("abort_fuse_fire", bus.fuse_fire, 0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    step();
    check("post_abort_rd_valid", bus.rd_valid, 0);
    check("post_abort_fuse_fire", bus.fuse_fire, 0);
    check("post_abort_live", bus.live_count, 0);

    // Fuse blow with all cells armed
    for (int i = 0; i < DEPTH; i++) begin
      set_init(i, 4'(i + 1), 8'd0, 8'd255); step();
    end
    check("live_all_armed", bus.live_count, 4);
    bus.fuse_blow = 1'b1; step();
    $display("fuse_blow applied");
    check("fuse_locked", bus.locked, 1);
    check("fuse_live", bus.live_count, 0);
    for (int i = 0; i < DEPTH; i++) begin
      set_read_auth(i, 4'(i + 1), 8'd100, 1'b0, 1'b0); step();
    end
    step();
    #1 reset_n = 1'b0;
    #1 check_reset_outputs("fuse_reset");
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    step();
    check("release_locked", bus.locked, 0);
    check("release_live", bus.live_count, 0);

`ifdef QKD_FAIL_LOCKOUT_EN
    // Three failed reads of empty cell 0 lock the bank
    for (int k = 0; k < 3; k++) begin
      set_read(0, 2'b00, 2'b00, 4'h0, 8'd0, 1'b0, 1'b0); step();
      check("lockout_locked", bus.locked, (k == 2) ? 1 : 0);
    end
    set_init(1, 4'h9, 8'd0, 8'd255); step();
    check("lockout_init_live", bus.live_count, 0);
    set_read_auth(1, 4'h9, 8'd100, 1'b0, 1'b0); step();
`endif

    repeat (2) step();
    check("scoreboard_drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
